// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel byte-serial memory arbiter with fixed or round-robin grant.
// Define MEM_ARB_ABORT_EN to add the per-channel read abort input.
module mem_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH-1:0]        we_i,
  input  logic [2*NUM_CH-1:0]      len_i,
  input  logic [ADDR_W*NUM_CH-1:0] addr_i,
  input  logic [32*NUM_CH-1:0]     wdata_i,
`ifdef MEM_ARB_ABORT_EN
  input  logic [NUM_CH-1:0]        abort_i,
`endif
  output logic [NUM_CH-1:0]        done_o,
  output logic [31:0]              rdata_o,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [31:0]              mem_a,
  output logic                     mem_wr
);
  localparam int CW = $clog2(NUM_CH);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] ch, rr, win, k;
  logic [ADDR_W-1:0] base, mem_a_q, a_sel;
  logic [2:0] cnt, n, n_sel;
  logic [1:0] l_sel;
  logic [31:0] wbuf, rbuf, rnext, w_sel;
  logic [NUM_CH-1:0] cand;
  logic wr_q, grant, last, kill;
  // cnt counts cycles in the transaction; a read spends one extra cycle for the bus read latency
  always_comb begin
    cand = req_i & ~done_o;
    kill = 1'b0;
`ifdef MEM_ARB_ABORT_EN
    cand = cand & ~abort_i;
    kill = state == READ && abort_i[ch];
`endif
    win = '0;
    k = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      k = CW'(ARB_MODE == 0 ? i : (int'(rr) + NUM_CH - 1 - i) % NUM_CH);
      if (cand[k]) win = k;
    end
    a_sel = addr_i[win*ADDR_W +: ADDR_W];
    l_sel = len_i[2*win +: 2];
    w_sel = wdata_i[32*win +: 32];
    n_sel = l_sel == 2'd0 ? 3'd1 : l_sel == 2'd1 ? 3'd2 : 3'd4;
    grant = state == IDLE && |cand;
    last = state == READ ? cnt == n : state == WRITE && cnt == n - 3'd1;
    rnext = rbuf;
    rnext[{cnt[1:0] - 2'd1, 3'b000} +: 8] = mem_din;
    state_nxt = state == IDLE ? (grant ? (we_i[win] ? WRITE : READ) : IDLE) : (last || kill) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else if (rdy) state <= state_nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ch <= '0;
      rr <= '0;
      base <= '0;
      mem_a_q <= '0;
      cnt <= '0;
      n <= '0;
      wbuf <= '0;
      rbuf <= '0;
      mem_dout <= '0;
      wr_q <= 1'b0;
      done_o <= '0;
      rdata_o <= '0;
    end else if (rdy) begin
      done_o <= '0;
      if (grant) begin
        ch <= win;
        base <= a_sel;
        mem_a_q <= a_sel;
        n <= n_sel;
        wbuf <= w_sel;
        cnt <= '0;
        rbuf <= '0;
        wr_q <= we_i[win];
        if (we_i[win]) mem_dout <= w_sel[7:0];
      end else if (state != IDLE && !kill) begin
        cnt <= cnt + 3'd1;
        if (state == READ && cnt != 3'd0) rbuf <= rnext;
        if (last) begin
          done_o[ch] <= 1'b1;
          rr <= ch == CW'(NUM_CH - 1) ? '0 : ch + 1'b1;
          wr_q <= 1'b0;
          if (state == READ) rdata_o <= rnext;
        end else if (cnt < n - 3'd1) begin
          mem_a_q <= base + ADDR_W'(cnt + 3'd1);
          if (state == WRITE) mem_dout <= wbuf[{cnt[1:0] + 2'd1, 3'b000} +: 8];
        end
      end
    end
  assign mem_a = 32'(mem_a_q);
  assign mem_wr = wr_q & rdy;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives a fixed-priority and a round-robin arbiter side by side against a cycle model.
module tb_mem_arbiter;
  localparam int NC = 2, AW = 32;
  logic clk = 0, rst = 0, rdy = 1;
  logic [NC-1:0] req [2];
  logic [NC-1:0] we = '0, abort = '0;
  logic [2*NC-1:0] len = '0;
  logic [AW*NC-1:0] addr = '0;
  logic [32*NC-1:0] wd = '0;
  logic [NC-1:0] done [2];
  logic [31:0] rdata [2], ma [2];
  logic [7:0] md [2], din [2];
  logic mw [2];
  int total = 0, bad = 0;
  bit chk_en = 0;
  int dc [2][NC];
  logic [31:0] dr [2][NC];
  int oc [2];
  logic [31:0] sa [16];
  logic sw [16];
  logic [7:0] sd [16];
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gu
    mem_arbiter #(.NUM_CH(NC), .ADDR_W(AW), .ARB_MODE(g)) u (
      .clk(clk), .rst(rst), .rdy(rdy), .req_i(req[g]), .we_i(we), .len_i(len),
      .addr_i(addr), .wdata_i(wd),
`ifdef MEM_ARB_ABORT_EN
      .abort_i(abort),
`endif
      .done_o(done[g]), .rdata_o(rdata[g]), .mem_din(din[g]), .mem_dout(md[g]),
      .mem_a(ma[g]), .mem_wr(mw[g]));
  end

  // bus memory: byte at address a is {a[3:0]+1, a[3:0]+1}, one-cycle registered read, frozen by rdy
  function automatic logic [7:0] rom(input logic [31:0] a);
    logic [3:0] b;
    b = a[3:0] + 4'd1;
    return {b, b};
  endfunction
  always @(posedge clk) if (rdy) for (int m = 0; m < 2; m++) din[m] <= rom(ma[m]);

  // model: kk = 1-based cycle number inside the transaction; reads occupy N+1 cycles, writes N
  bit busy [2], mwe [2];
  int own [2], kk [2], nb [2], rrp [2];
  logic [31:0] mbase [2], mwd [2], r_exp [2], a_exp [2];
  logic [7:0] d_exp [2];
  logic [NC-1:0] dn [2];
  always @(posedge clk or negedge rst) begin : model
    logic [NC-1:0] nd, cand;
    int w, lv;
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        busy[m] = 0; mwe[m] = 0; own[m] = 0; kk[m] = 0; nb[m] = 0; rrp[m] = 0;
        mbase[m] = 0; mwd[m] = 0; r_exp[m] = 0; a_exp[m] = 0; d_exp[m] = 0; dn[m] = '0;
      end
    end else if (rdy) begin
      for (int m = 0; m < 2; m++) begin
        nd = '0;
        if (busy[m]) begin
          if (!mwe[m] && abort[own[m]]) busy[m] = 0;
          else if (kk[m] == (mwe[m] ? nb[m] : nb[m] + 1)) begin
            busy[m] = 0;
            nd[own[m]] = 1'b1;
            rrp[m] = (own[m] + 1) % NC;
            if (!mwe[m]) begin
              r_exp[m] = 0;
              for (int i = 0; i < nb[m]; i++) r_exp[m] = r_exp[m] | (32'(rom(mbase[m] + 32'(i))) << (8 * i));
            end
          end else kk[m] = kk[m] + 1;
        end else begin
          cand = req[m] & ~dn[m] & ~abort;
          w = -1;
          if (m == 0) begin
            for (int i = NC - 1; i >= 0 && w < 0; i--) if (cand[i]) w = i;
          end else begin
            for (int i = 0; i < NC && w < 0; i++) if (cand[(rrp[m] + i) % NC]) w = (rrp[m] + i) % NC;
          end
          if (w >= 0) begin
            busy[m] = 1; kk[m] = 1; own[m] = w; mwe[m] = we[w];
            lv = int'(len[2*w +: 2]);
            nb[m] = lv == 0 ? 1 : lv == 1 ? 2 : 4;
            mbase[m] = addr[w*AW +: AW];
            mwd[m] = wd[w*32 +: 32];
          end
        end
        dn[m] = nd;
        if (busy[m] && kk[m] <= nb[m]) begin
          a_exp[m] = mbase[m] + 32'(kk[m] - 1);
          if (mwe[m]) d_exp[m] = 8'(mwd[m] >> (8 * (kk[m] - 1)));
        end
      end
    end
  end

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s u%0d got=%h want=%h t=%0t", nm, m, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) for (int m = 0; m < 2; m++) begin
    chk("done", m, 32'(done[m]), 32'(dn[m]));
    chk("rdata", m, rdata[m], r_exp[m]);
    chk("mem_a", m, ma[m], a_exp[m]);
    chk("mem_wr", m, {31'b0, mw[m]}, {31'b0, busy[m] && mwe[m] && kk[m] <= nb[m] && rdy});
    chk("mem_dout", m, {24'b0, md[m]}, {24'b0, d_exp[m]});
  end

  // one directed run of 24 cycles; cycle 0 is the cycle in which m0 is first requested
  task automatic serve(input logic [NC-1:0] m0, input logic [NC-1:0] lm, input int lc,
                       input int ps, input int pl, input int rc, input logic [NC-1:0] am, input int ac);
    logic [NC-1:0] clr [2];
    clr[0] = '0; clr[1] = '0;
    for (int m = 0; m < 2; m++) for (int c = 0; c < NC; c++) begin dc[m][c] = -1; dr[m][c] = 'x; end
    @(posedge clk); #1;
    req[0] = m0; req[1] = m0;
    for (int c = 0; c < 24; c++) begin
      for (int m = 0; m < 2; m++) begin req[m] = req[m] & ~clr[m]; clr[m] = '0; end
      if (c == lc) begin req[0] = req[0] | lm; req[1] = req[1] | lm; end
      rdy = !(c >= ps && c < ps + pl);
      abort = c == ac ? am : '0;
      if (c == ac) begin req[0] = req[0] & ~am; req[1] = req[1] & ~am; end
      if (c == rc) begin rst = 0; req[0] = '0; req[1] = '0; end
      if (c == rc + 1) rst = 1;
      @(negedge clk);
      if (c < 16) begin sa[c] = ma[0]; sw[c] = mw[0]; sd[c] = md[0]; end
      for (int m = 0; m < 2; m++) for (int h = 0; h < NC; h++) if (done[m][h]) begin
        dc[m][h] = c; dr[m][h] = rdata[m]; oc[m] = oc[m] * 10 + h + 1; clr[m][h] = 1'b1;
      end
      @(posedge clk); #1;
    end
    rdy = 1; abort = '0; req[0] = '0; req[1] = '0;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    req[0] = '0; req[1] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1; chk_en = 1;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("rst_mem_a", m, ma[m], 32'h0);
      chk("rst_rdata", m, rdata[m], 32'h0);
      chk("rst_done", m, 32'(done[m]), 32'h0);
      chk("rst_wr", m, {31'b0, mw[m]}, 32'h0);
    end
    // 4-byte read at 0x100
    addr[0 +: 32] = 32'h100; len[1:0] = 2'b10; we[0] = 0;
    serve(2'b01, '0, -1, -1, 0, -1, '0, -1);
    for (int m = 0; m < 2; m++) begin
      chk("rd4_cyc", m, dc[m][0], 6);
      chk("rd4_data", m, dr[m][0], 32'h44332211);
    end
    chk("rd4_a1", 0, sa[1], 32'h100);
    chk("rd4_a4", 0, sa[4], 32'h103);
    // 1-byte write at 0x30000
    addr[32 +: 32] = 32'h30000; len[3:2] = 2'b00; we[1] = 1; wd[32 +: 32] = 32'h41;
    serve(2'b10, '0, -1, -1, 0, -1, '0, -1);
    for (int m = 0; m < 2; m++) chk("wr1_cyc", m, dc[m][1], 2);
    chk("wr1_wr1", 0, {31'b0, sw[1]}, 32'h1);
    chk("wr1_a1", 0, sa[1], 32'h30000);
    chk("wr1_d1", 0, {24'b0, sd[1]}, 32'h41);
    chk("wr1_wr2", 0, {31'b0, sw[2]}, 32'h0);
    // len=11 read with a 3-cycle pause starting in cycle 3
    len[1:0] = 2'b11;
    serve(2'b01, '0, -1, 3, 3, -1, '0, -1);
    for (int m = 0; m < 2; m++) begin
      chk("pause_cyc", m, dc[m][0], 9);
      chk("pause_data", m, dr[m][0], 32'h44332211);
    end
    chk("pause_a_held", 0, sa[5], 32'h102);
    // reset during a 4-byte write, then a normal 2-byte write
    addr[0 +: 32] = 32'h400; len[1:0] = 2'b10; we[0] = 1; wd[0 +: 32] = 32'hA1B2C3D4;
    serve(2'b01, '0, -1, -1, 0, 2, '0, -1);
    for (int m = 0; m < 2; m++) chk("rst_nodone", m, dc[m][0], -1);
    chk("rst_wr_low", 0, {31'b0, sw[2]}, 32'h0);
    addr[32 +: 32] = 32'h200; len[3:2] = 2'b01; wd[32 +: 32] = 32'h5566;
    serve(2'b10, '0, -1, -1, 0, -1, '0, -1);
    for (int m = 0; m < 2; m++) chk("wr2_cyc", m, dc[m][1], 3);
    chk("wr2_d1", 0, {24'b0, sd[1]}, 32'h66);
    chk("wr2_d2", 0, {24'b0, sd[2]}, 32'h55);
    chk("wr2_a2", 0, sa[2], 32'h201);
    // 2-byte read, zero-extended
    addr[32 +: 32] = 32'h105; we[1] = 0;
    serve(2'b10, '0, -1, -1, 0, -1, '0, -1);
    for (int m = 0; m < 2; m++) begin
      chk("rd2_cyc", m, dc[m][1], 4);
      chk("rd2_data", m, dr[m][1], 32'h00007766);
    end
    // address wrap at 2^32
    addr[0 +: 32] = 32'hFFFFFFFE; we[0] = 0; len[1:0] = 2'b10;
    serve(2'b01, '0, -1, -1, 0, -1, '0, -1);
    chk("wrap_data", 0, dr[0][0], 32'h221100FF);
    chk("wrap_a3", 0, sa[3], 32'h0);
    chk("wrap_a4", 0, sa[4], 32'h1);
    // simultaneous requests: fixed priority vs round-robin
    reset_pulse();
    addr[0 +: 32] = 32'h100; addr[32 +: 32] = 32'h102; len = '0; we = '0;
    oc[0] = 0; oc[1] = 0;
    serve(2'b11, '0, -1, -1, 0, -1, '0, -1);
    chk("fix_ch1_cyc", 0, dc[0][1], 3);
    chk("fix_ch0_cyc", 0, dc[0][0], 6);
    chk("rr_ch0_cyc", 1, dc[1][0], 3);
    chk("rr_ch1_cyc", 1, dc[1][1], 6);
    chk("fix_ch1_data", 0, dr[0][1], 32'h33);
    chk("rr_ch0_data", 1, dr[1][0], 32'h11);
    serve(2'b11, '0, -1, -1, 0, -1, '0, -1);
    chk("fix_order", 0, oc[0], 2121);
    chk("rr_order", 1, oc[1], 1212);
`ifdef MEM_ARB_ABORT_EN
    // abort ch0 2-byte read in cycle 2; ch1 waiting since cycle 1
    len[1:0] = 2'b01;
    serve(2'b01, 2'b10, 1, -1, 0, -1, 2'b01, 2);
    for (int m = 0; m < 2; m++) begin
      chk("abort_nodone", m, dc[m][0], -1);
      chk("abort_ch1_cyc", m, dc[m][1], 6);
      chk("abort_ch1_data", m, dr[m][1], 32'h33);
    end
`endif
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
